// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int         NIBBLE_W       = 4;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that has reached 5 or more.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_in,
    output logic [NIBBLE_W-1:0] nibble_out
);

    // The sum stays 4 bits wide; a corrected nibble never carries into its neighbour.
    assign nibble_out = (nibble_in >= ADD3_THRESHOLD) ? nibble_in + 4'd3 : nibble_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 converter from WIDTH-bit binary to DIGITS packed BCD nibbles.
// Define BCD_BLANK_EN to register a leading-zero blank mask alongside each result.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int DIGITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NIBBLE_W*DIGITS-1:0] bcd_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic [DIGITS-1:0]          digit_blank
);

    localparam int BCD_W = NIBBLE_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    state_t            state;
    state_t            state_next;
    logic [SR_W-1:0]   shift_reg;
    logic [SR_W-1:0]   shifted;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_new;
    logic [CNT_W-1:0]  bit_cnt;
    logic              accept;
    logic              last_shift;
    logic              unused_top_bit;

    // One correction cell per BCD nibble of the upper shift-register field.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble_in  (shift_reg[WIDTH + NIBBLE_W*g +: NIBBLE_W]),
            .nibble_out (bcd_adj[NIBBLE_W*g +: NIBBLE_W])
        );
    end

    // The top BCD bit can never be set for legal WIDTH/DIGITS pairs, so it shifts out.
    assign shifted        = {bcd_adj[BCD_W-2:0], shift_reg[WIDTH-1:0], 1'b0};
    assign bcd_new        = shifted[SR_W-1 -: BCD_W];
    assign unused_top_bit = bcd_adj[BCD_W-1];
    assign accept         = in_valid && in_ready;
    assign last_shift     = (state == SHIFT) && (bit_cnt == LAST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (bit_cnt == LAST_SHIFT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:  in_ready = 1'b1;
            SHIFT: busy     = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments here, so shift_reg, bit_cnt and bcd_out all see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            bcd_out   <= '0;
        end else begin
            if (accept) begin
                shift_reg <= {{BCD_W{1'b0}}, in_data};
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
                shift_reg <= shifted;
                bit_cnt   <= bit_cnt + 1'b1;
            end
            // Loaded on the edge entering DONE so it is stable while out_valid is high.
            if (last_shift) bcd_out <= bcd_new;
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_above;

    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above && (bcd_new[NIBBLE_W*k +: NIBBLE_W] == '0);
            blank_next[k] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             digit_blank <= '0;
        else if (last_shift) digit_blank <= blank_next;
    end
`else
    assign digit_blank = '0;
`endif

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential shift-and-add-3 ("double dabble") converter from binary to packed BCD.
- Sits directly upstream of the seven-segment display driver and feeds it 8 ready-made decimal digits.
- Replaces the per-cycle combinational divide/modulo chain with a small, timing-friendly iterative datapath.
- Takes a WIDTH-bit unsigned value through a valid/ready handshake and returns DIGITS BCD nibbles after a fixed latency.

Parameters:
WIDTH, 24, binary input width; must satisfy 2^WIDTH-1 < 10^DIGITS
DIGITS, 8, number of BCD output digits (nibbles)

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous, active-high reset
in_data  input  WIDTH  unsigned binary value to convert
in_valid  input  1  in_data is valid
in_ready  output  1  converter idle and able to accept
bcd_out  output  4*DIGITS  packed BCD; digit k is [4k+3:4k], digit 0 is the least significant
out_valid  output  1  one-cycle pulse when bcd_out is updated
busy  output  1  conversion in progress (state SHIFT or DONE)
digit_blank  output  DIGITS  leading-zero blank mask; bit k=1 means digit k is blank

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); every register is cleared on the rst edge.
- Reset values: in_ready=1, out_valid=0, busy=0, bcd_out=0, digit_blank=0, state=IDLE, bit counter=0.
- States:
  - IDLE: in_ready=1. On in_valid at a clk edge, load the shift register with {DIGITS*4 zeros, in_data}, set counter=0, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is >=5, then shift the whole register left by 1, then increment counter. After the WIDTH-th shift, go to DONE.
  - DONE: register the BCD field into bcd_out, pulse out_valid for 1 cycle, go to IDLE.
- Latency:
  - Accept edge at cycle 0, SHIFT during cycles 1..WIDTH, out_valid high in cycle WIDTH+1 (25 for defaults).
  - Next accept is possible at cycle WIDTH+2.
  - Throughput is one conversion per WIDTH+2 cycles.
- Handshake:
  - A transfer occurs only when in_valid && in_ready. in_data is sampled on the accept edge only.
  - in_valid while busy is ignored: no queueing, no error flag.
  - In IDLE, in_ready stays 1 regardless of in_valid.
- Output holding: bcd_out keeps the last result until the next DONE; it never shows partial values. The display reads bcd_out continuously.
- Counter: width is clog2(WIDTH+1). It never wraps during a conversion and is reset on each accept.
- Arithmetic:
  - Add-3 is applied per nibble on a 4-bit value; the result must not carry into the next nibble (4-bit truncation).
  - Input is unsigned; the maximum input 2^WIDTH-1 must yield correct digits.
- Reset mid-conversion: abort immediately; bcd_out=0, no out_valid pulse, in_ready=1 in the cycle after the reset edge.
- rst and in_valid on the same edge: rst wins and nothing is accepted.

Optional Feature:
Macro BCD_BLANK_EN.
- Defined: in DONE, digit_blank is registered alongside bcd_out. Bit k=1 iff digit k and all digits above it are 0. Bit 0 is always 0, so a zero value shows a single "0".
- Undefined: digit_blank is held at all zeros and no blanking logic is synthesised.
- Port list is identical in both builds.

Decomposition:
- Shared package holds:
  - BCD nibble width constant (4)
  - ADD3 threshold constant (5)
  - state encoding typedef/localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
- Sub-module bcd_add3: a 4-bit combinational correction cell (in>=5 ? in+3 : in), instantiated DIGITS times via generate.
- The FSM, counter and shift register stay in bin2bcd_seq.

Test Plan:
- Reset then in_data=0, in_valid pulse -> out_valid exactly 25 cycles after accept; bcd_out=32'h0000_0000; with BCD_BLANK_EN, digit_blank=8'b1111_1110.
- in_data=16777215 -> bcd_out=32'h1677_7215; in_data=1234567 -> bcd_out=32'h0123_4567; in_data=42 -> bcd_out=32'h0000_0042, digit_blank=8'b1111_1100 (BCD_BLANK_EN).
- in_valid held high continuously with values 10 then 99 -> accepts spaced 26 cycles apart; results 32'h0000_0010, then 32'h0000_0099; in_ready low for cycles 1..25 after each accept.
- Accept 500, then pulse in_valid with 777 at cycle 10 -> 777 ignored; result 32'h0000_0500; bcd_out keeps the previous value until out_valid.
- Accept 123456, assert rst at cycle 12 -> no out_valid; bcd_out=0, in_ready=1 next cycle; a new 9 afterwards -> bcd_out=32'h0000_0009.
- Randomised sweep of 1000 values against a reference model (decimal digits via /10^k %10) -> exact match on every out_valid.
